// File: rtl/sti_pixel_streamer_if.sv
// Pixel stream from the sti streamer to the init pass: valid/ready handshake carrying
// the pixel value, its res address and an end-of-frame marker.
interface sti_pixel_streamer_if #(
    parameter int PIX_AW = 14
);
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic [PIX_AW-1:0] pix_addr;
    logic              pix_last;

    modport master (output pix_valid, pix_data, pix_addr, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_addr, pix_last, output pix_ready);
endinterface

// File: rtl/sti_pixel_streamer.sv
// Reads the binary image from the sti ROM and streams it one pixel per cycle to the init pass.
// Build option: define STI_BORDER_CLEAR_EN to force the one-pixel image border to zero.
module sti_pixel_streamer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [ADDR_W-1:0] sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    sti_pixel_streamer_if.master pix
);
    localparam int NUM_WORDS = IMG_W * IMG_H / WORD_W;
    localparam int PIX_AW    = $clog2(IMG_W * IMG_H);
    localparam int COL_W     = $clog2(IMG_W);
    localparam int BIT_W     = $clog2(WORD_W);
    localparam logic [PIX_AW-1:0] LAST_ADDR = PIX_AW'(IMG_W * IMG_H - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   WORDS_END = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FIN} state_t;

    state_t            state;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] nxt_word;
    logic              cur_valid;
    logic              nxt_valid;
    logic              rd_pend;
    logic [BIT_W-1:0]  bit_idx;
    logic [ADDR_W:0]   issued;
    logic [PIX_AW-1:0] pix_addr_q;

    logic       fire;
    logic       pop;
    logic       last_fire;
    logic       start_go;
    logic       want_rd;
    logic [2:0] occupancy;
    logic       pix_bit;

    // Words held plus words requested, as they will stand after this edge.
    always_comb begin
        fire      = cur_valid & pix.pix_ready;
        pop       = fire & (bit_idx == LAST_BIT);
        last_fire = fire & (pix_addr_q == LAST_ADDR);
        start_go  = (state == IDLE) & start;
        occupancy = {2'b00, cur_valid} + {2'b00, nxt_valid} + {2'b00, rd_pend}
                  + {2'b00, sti_rd} - {2'b00, pop};
        want_rd   = start_go
                  | (((state == FETCH) | (state == STREAM)) & (occupancy < 3'd2)
                     & (issued < WORDS_END));
    end

`ifdef STI_BORDER_CLEAR_EN
    logic [PIX_AW-COL_W-1:0] row;
    logic [COL_W-1:0]        col;
    logic                    border;

    always_comb begin
        row     = pix_addr_q[PIX_AW-1:COL_W];
        col     = pix_addr_q[COL_W-1:0];
        border  = (row == '0) | (row == (PIX_AW-COL_W)'(IMG_H - 1))
                | (col == '0) | (col == COL_W'(IMG_W - 1));
        pix_bit = cur_word[WORD_W-1] & ~border;
    end
`else
    always_comb pix_bit = cur_word[WORD_W-1];
`endif

    assign pix.pix_valid = cur_valid;
    assign pix.pix_data  = {7'd0, pix_bit};
    assign pix.pix_addr  = pix_addr_q;
    assign pix.pix_last  = cur_valid & (pix_addr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sti_rd     <= 1'b0;
            sti_addr   <= '0;
            rd_pend    <= 1'b0;
            issued     <= '0;
            cur_word   <= '0;
            nxt_word   <= '0;
            cur_valid  <= 1'b0;
            nxt_valid  <= 1'b0;
            bit_idx    <= '0;
            pix_addr_q <= '0;
        end else begin
            done    <= 1'b0;
            rd_pend <= sti_rd;
            sti_rd  <= want_rd;
            if (start_go) begin
                sti_addr <= '0;
                issued   <= (ADDR_W + 1)'(1);
            end else if (want_rd) begin
                sti_addr <= issued[ADDR_W-1:0];
                issued   <= issued + 1'b1;
            end

            case (state)
                IDLE: if (start) begin
                    state      <= FETCH;
                    busy       <= 1'b1;
                    bit_idx    <= '0;
                    pix_addr_q <= '0;
                end
                FETCH:  if (rd_pend) state <= STREAM;
                STREAM: if (last_fire) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FIN:    state <= IDLE;
            endcase

            if (fire) begin
                bit_idx    <= bit_idx + 1'b1;
                pix_addr_q <= pix_addr_q + 1'b1;
                cur_word   <= cur_word << 1;
            end
            // A word landing on the cycle the current one retires goes straight to the head.
            if (pop) begin
                if (nxt_valid) begin
                    cur_word  <= nxt_word;
                    cur_valid <= 1'b1;
                    nxt_valid <= rd_pend;
                    if (rd_pend) nxt_word <= sti_di;
                end else begin
                    cur_word  <= sti_di;
                    cur_valid <= rd_pend;
                end
            end else if (rd_pend) begin
                if (!cur_valid) begin
                    cur_word  <= sti_di;
                    cur_valid <= 1'b1;
                end else begin
                    nxt_word  <= sti_di;
                    nxt_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sti_pixel_streamer.sv
// Self-checking bench for sti_pixel_streamer: ROM model, expected-pixel scoreboard, stall/reset/restart cases.
module tb_sti_pixel_streamer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di = '0;

    sti_pixel_streamer_if pix_if ();

    sti_pixel_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sti_rd   (sti_rd),
        .sti_addr (sti_addr),
        .sti_di   (sti_di),
        .pix      (pix_if.master)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [1024];
    always @(posedge clk) if (sti_rd) sti_di <= rom[sti_addr];

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        last;
    } pix_t;

    pix_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    int   exp_rd_addr = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    int   ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] model_pix(input int p);
        logic [15:0] w;
        logic        b;
        int          row;
        int          col;
        w   = rom[p / 16];
        b   = w[15 - (p % 16)];
        row = p / 128;
        col = p % 128;
`ifdef STI_BORDER_CLEAR_EN
        if (row == 0 || row == 127 || col == 0 || col == 127) b = 1'b0;
`else
        if (row < 0 || col < 0) b = 1'b0;
`endif
        return {7'd0, b};
    endfunction

    // Consumer ready pattern: 0 = always, 1 = random 50%, 2 = held low.
    initial begin
        pix_if.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_if.pix_ready = 1'b1;
                1:       pix_if.pix_ready = 1'($urandom_range(0, 1));
                default: pix_if.pix_ready = 1'b0;
            endcase
        end
    end

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic [13:0] prev_addr;
    logic        exp_done_q = 1'b0;
    logic        avail;
    pix_t        e;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            exp_done_q = 1'b0;
        end else begin
            if (done || exp_done_q) check("done_pulse", 32'(done), 32'(exp_done_q));
            if (done) done_cnt++;
            exp_done_q = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 32'(pix_if.pix_valid), 32'd1);
                check("hold_data", 32'(pix_if.pix_data), 32'(prev_data));
                check("hold_addr", 32'(pix_if.pix_addr), 32'(prev_addr));
            end
            if (sti_rd) begin
                check("rd_addr", 32'(sti_addr), 32'(exp_rd_addr));
                exp_rd_addr++;
                rd_cnt++;
            end
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                avail = (sb.size() != 0);
                check("sb_avail", 32'(avail), 32'd1);
                if (avail) begin
                    e = sb.pop_front();
                    check("pix_addr", 32'(pix_if.pix_addr), 32'(e.addr));
                    check("pix_data", 32'(pix_if.pix_data), 32'(e.data));
                    check("pix_last", 32'(pix_if.pix_last), 32'(e.last));
                    exp_done_q = e.last;
                end
            end
            prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
            prev_data  = pix_if.pix_data;
            prev_addr  = pix_if.pix_addr;
        end
    end

    task automatic start_frame();
        pix_t p;
        sb.delete();
        for (int i = 0; i < 16384; i++) begin
            p.addr = 14'(i);
            p.data = model_pix(i);
            p.last = (i == 16383);
            sb.push_back(p);
        end
        rd_cnt      = 0;
        exp_rd_addr = 0;
        done_base   = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_sti_rd", 32'(sti_rd), 32'd1);
        check("c1_sti_addr", 32'(sti_addr), 32'd0);
        tick();
        check("c2_valid", 32'(pix_if.pix_valid), 32'd0);
        tick();
        check("c3_valid", 32'(pix_if.pix_valid), 32'd1);
        check("c3_addr", 32'(pix_if.pix_addr), 32'd0);
    endtask

    task automatic end_frame(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_cnt != done_base) break;
            tick();
        end
        check("frame_done", 32'(done_cnt != done_base), 32'd1);
        repeat (5) tick();
        check("done_once", 32'(done_cnt - done_base), 32'd1);
        check("rd_count", 32'(rd_cnt), 32'd1024);
        check("sb_left", 32'(sb.size()), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_valid", 32'(pix_if.pix_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sti_rd", 32'(sti_rd), 32'd0);
        check("rst_sti_addr", 32'(sti_addr), 32'd0);
        check("rst_valid", 32'(pix_if.pix_valid), 32'd0);
        check("rst_last", 32'(pix_if.pix_last), 32'd0);
        check("rst_paddr", 32'(pix_if.pix_addr), 32'd0);
        check("rst_pdata", 32'(pix_if.pix_data), 32'd0);
        reset = 1'b1;
        tick();

        // All-ones image, with a stray start mid-frame that must be ignored.
        for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
        ready_mode = 0;
        start_frame();
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_start_busy", 32'(busy), 32'd1);
        end_frame(20000);

        // Word k = k checks bit order; a fresh start after done runs a full frame.
        for (int i = 0; i < 1024; i++) rom[i] = 16'(i);
        start_frame();
        end_frame(20000);

        // Random image under a 50% ready pattern.
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        ready_mode = 1;
        start_frame();
        end_frame(45000);

        // Reset at pixel 5000 aborts the frame without a done pulse.
        for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 37 + 5);
        ready_mode = 0;
        start_frame();
        for (int i = 0; i < 6000; i++) begin
            if (pix_if.pix_addr == 14'd5000) break;
            tick();
        end
        check("reach_5000", 32'(pix_if.pix_addr), 32'd5000);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sti_rd", 32'(sti_rd), 32'd0);
        check("abort_valid", 32'(pix_if.pix_valid), 32'd0);
        check("abort_paddr", 32'(pix_if.pix_addr), 32'd0);
        check("abort_pdata", 32'(pix_if.pix_data), 32'd0);
        check("abort_sti_addr", 32'(sti_addr), 32'd0);
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt), 32'(done_base));
        reset = 1'b1;
        tick();

        // Restart after abort, holding ready low for 40 cycles after the first valid.
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        ready_mode = 2;
        start_frame();
        repeat (40) tick();
        check("stall_reads_le3", 32'(rd_cnt <= 3), 32'd1);
        check("stall_paddr", 32'(pix_if.pix_addr), 32'd0);
        check("stall_valid", 32'(pix_if.pix_valid), 32'd1);
        ready_mode = 0;
        end_frame(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
